note_tone_gen: RTL and testbench

- Playback end of the transcription path: consumes the 6-bit note index produced by the bin-to-note lookup and synthesizes a square-wave tone at that note's pitch.
- Output is an audio sample stream for the DAC/PWM stage.
- Uses a phase accumulator with an attack/sustain/release amplitude envelope so note changes do not click.
- Pitch is set by a per-note phase-increment table that mirrors the lookup's bin-floor table.

---
 rtl/note_pkg.sv | 55 +++++
 rtl/note_tone_gen_if.sv | 24 ++
 rtl/env_ramp.sv | 28 ++
 rtl/note_tone_gen.sv | 139 +++++++++++++
 tb/tb_note_tone_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Note tables shared by the bin-to-note lookup and the tone generator.
// The phase-increment table is derived from the bin floors so that the two tables cannot drift apart.
package note_pkg;

  localparam int unsigned PHASE_W    = 24;
  localparam int unsigned AMP_W      = 8;
  localparam int unsigned ENV_STEP   = 8;
  localparam int unsigned AMP_MAX    = 255;
  localparam int unsigned AMP_SHIFT  = 7;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned NUM_NOTES  = 22;
  localparam int unsigned NOTE_IDX_W = 6;
  localparam int unsigned NOTE_K_W   = 5;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned FS_HZ      = 8000;
  localparam int unsigned FFT_N      = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [BIN_W-1:0] NOTE_BIN_FLOOR [0:NUM_NOTES-1] = '{
    8'd0,  8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd18, 8'd19, 8'd21, 8'd22, 8'd24, 8'd25, 8'd27, 8'd28, 8'd30, 8'd32, 8'd34
  };

  // round(f_k * 2^PHASE_W / FS), f_k = centre of bins floor[k-1]..floor[k] at FS/FFT_N Hz per bin
  function automatic logic [PHASE_W-1:0] note_phase_inc(input logic [NOTE_K_W-1:0] k);
    logic [63:0] num;
    logic [63:0] den;
    if (k == '0) return '0;
    num = ((64'(NOTE_BIN_FLOOR[k - NOTE_K_W'(1)]) + 64'(NOTE_BIN_FLOOR[k])) * 64'(FS_HZ)) << PHASE_W;
    den = 64'(2 * FFT_N * FS_HZ);
    return PHASE_W'((num + (den >> 1)) / den);
  endfunction

  localparam logic [PHASE_W-1:0] NOTE_PHASE_INC [0:NUM_NOTES-1] = '{
    note_phase_inc(5'd0),  note_phase_inc(5'd1),  note_phase_inc(5'd2),  note_phase_inc(5'd3),
    note_phase_inc(5'd4),  note_phase_inc(5'd5),  note_phase_inc(5'd6),  note_phase_inc(5'd7),
    note_phase_inc(5'd8),  note_phase_inc(5'd9),  note_phase_inc(5'd10), note_phase_inc(5'd11),
    note_phase_inc(5'd12), note_phase_inc(5'd13), note_phase_inc(5'd14), note_phase_inc(5'd15),
    note_phase_inc(5'd16), note_phase_inc(5'd17), note_phase_inc(5'd18), note_phase_inc(5'd19),
    note_phase_inc(5'd20), note_phase_inc(5'd21)
  };

  // {1, k} with 1 <= k <= NUM_NOTES-1 is a note; everything else is silence
  function automatic logic note_idx_is_note(input logic [NOTE_IDX_W-1:0] idx);
    return idx[NOTE_IDX_W-1] && (idx[NOTE_K_W-1:0] != '0) &&
           (idx[NOTE_K_W-1:0] <= NOTE_K_W'(NUM_NOTES - 1));
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note handshake and sample stream of the tone generator, plus debug taps.
interface note_tone_gen_if;
  import note_pkg::*;

  logic                         note_valid_in;
  logic [NOTE_IDX_W-1:0]        note_index_in;
  logic                         note_ready_out;
  logic                         sample_tick_in;
  logic signed [SAMPLE_W-1:0]   sample_out;
  logic                         sample_valid_out;
  logic [PHASE_W-1:0]           phase_out;
  logic [1:0]                   state_out;

  modport master (
    output note_valid_in, note_index_in, sample_tick_in,
    input  note_ready_out, sample_out, sample_valid_out, phase_out, state_out
  );

  modport slave (
    input  note_valid_in, note_index_in, sample_tick_in,
    output note_ready_out, sample_out, sample_valid_out, phase_out, state_out
  );

endinterface

// File: rtl/env_ramp.sv
// Envelope amplitude register with saturating up/down steps.
// The flags report whether the next step in that direction lands on the limit.
module env_ramp
  import note_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_up,
  input  logic             step_down,
  output logic [AMP_W-1:0] amp,
  output logic             at_max_c,
  output logic             at_zero_c
);

  assign at_max_c  = (amp >= AMP_W'(AMP_MAX - ENV_STEP));
  assign at_zero_c = (amp <= AMP_W'(ENV_STEP));

  always_ff @(posedge clk) begin
    if (rst) begin
      amp <= '0;
    end else if (step_up) begin
      amp <= at_max_c ? AMP_W'(AMP_MAX) : amp + AMP_W'(ENV_STEP);
    end else if (step_down) begin
      amp <= at_zero_c ? '0 : amp - AMP_W'(ENV_STEP);
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: phase accumulator at the accepted note's pitch,
// shaped by an attack/sustain/release envelope so note changes do not click.
module note_tone_gen
  import note_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  note_tone_gen_if.slave bus
);

  env_state_t            state, state_nxt;
  logic [NOTE_K_W-1:0]   cur_note, cur_note_nxt;
  logic [NOTE_K_W-1:0]   pending_note, pending_note_nxt;
  logic                  pending, pending_nxt;
  logic [PHASE_W-1:0]    phase, phase_nxt;
  logic                  ready;
  logic [SAMPLE_W-1:0]   sample;
  logic                  sample_valid;

  logic                  accept_c;
  logic                  is_note_c;
  logic [NOTE_K_W-1:0]   note_k_c;
  logic                  step_up_c;
  logic                  step_down_c;
  logic [AMP_W-1:0]      amp;
  logic                  at_max_c;
  logic                  at_zero_c;
  logic [SAMPLE_W-1:0]   mag_c;
  logic [SAMPLE_W-1:0]   sample_c;

  assign accept_c  = bus.note_valid_in && ready;
  assign is_note_c = note_idx_is_note(bus.note_index_in);
  assign note_k_c  = bus.note_index_in[NOTE_K_W-1:0];

  env_ramp u_env_ramp (
    .clk       (clk_in),
    .rst       (rst_in),
    .step_up   (step_up_c),
    .step_down (step_down_c),
    .amp       (amp),
    .at_max_c  (at_max_c),
    .at_zero_c (at_zero_c)
  );

  // Note acceptance first, then the tick update runs against the post-acceptance state
  always_comb begin
    state_nxt        = state;
    cur_note_nxt     = cur_note;
    pending_note_nxt = pending_note;
    pending_nxt      = pending;
    phase_nxt        = phase;
    step_up_c        = 1'b0;
    step_down_c      = 1'b0;

    if (accept_c) begin
      unique case (state)
        IDLE: begin
          if (is_note_c) begin
            state_nxt    = ATTACK;
            cur_note_nxt = note_k_c;
            phase_nxt    = '0;
          end
        end
        SUSTAIN: begin
          if (!is_note_c) begin
            state_nxt   = RELEASE;
            pending_nxt = 1'b0;
          end else if (note_k_c != cur_note) begin
            state_nxt        = RELEASE;
            pending_note_nxt = note_k_c;
            pending_nxt      = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (bus.sample_tick_in) begin
      unique case (state_nxt)
        IDLE: phase_nxt = '0;
        ATTACK: begin
          step_up_c = 1'b1;
          phase_nxt = phase_nxt + NOTE_PHASE_INC[cur_note_nxt];
          if (at_max_c) state_nxt = SUSTAIN;
        end
        SUSTAIN: phase_nxt = phase_nxt + NOTE_PHASE_INC[cur_note_nxt];
        RELEASE: begin
          step_down_c = 1'b1;
          if (at_zero_c) begin
            phase_nxt = '0;
            if (pending_nxt) begin
              state_nxt    = ATTACK;
              cur_note_nxt = pending_note_nxt;
              pending_nxt  = 1'b0;
            end else begin
              state_nxt    = IDLE;
              cur_note_nxt = '0;
            end
          end else begin
            phase_nxt = phase_nxt + NOTE_PHASE_INC[cur_note_nxt];
          end
        end
      endcase
    end
  end

  // Sample uses the amp/phase held before this tick's update
  assign mag_c    = SAMPLE_W'(amp) << AMP_SHIFT;
  assign sample_c = phase[PHASE_W-1] ? (SAMPLE_W'(0) - mag_c) : mag_c;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cur_note     <= '0;
      pending_note <= '0;
      pending      <= 1'b0;
      phase        <= '0;
      ready        <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_note     <= cur_note_nxt;
      pending_note <= pending_note_nxt;
      pending      <= pending_nxt;
      phase        <= phase_nxt;
      ready        <= (state_nxt == IDLE) || (state_nxt == SUSTAIN);
      sample_valid <= bus.sample_tick_in;
      if (bus.sample_tick_in) sample <= sample_c;
    end
  end

  assign bus.note_ready_out   = ready;
  assign bus.sample_out       = sample;
  assign bus.sample_valid_out = sample_valid;
  assign bus.phase_out        = phase;
  assign bus.state_out        = state;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed envelope scenarios then random notes/ticks/resets,
// every cycle compared against a behavioural envelope/pitch model.
module tb_note_tone_gen;
  import note_pkg::*;

  localparam int S_IDLE = 0;
  localparam int S_ATT  = 1;
  localparam int S_SUS  = 2;
  localparam int S_REL  = 3;

  logic clk;
  logic rst;
  note_tone_gen_if bus();

  note_tone_gen dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_state, m_amp, m_cur, m_pend_note, m_sample;
  bit          m_pend, m_svalid;
  int unsigned m_phase;
  int unsigned inc_tab [0:21];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [5:0] idx, input bit tk);
    int k;
    bit is_note;
    if (r) begin
      m_state = S_IDLE; m_amp = 0; m_phase = 0; m_cur = 0;
      m_pend = 0; m_pend_note = 0; m_sample = 0; m_svalid = 0;
      return;
    end
    k = int'(idx[4:0]);
    is_note = idx[5] && k >= 1 && k <= 21;
    m_svalid = tk;
    if (tk) m_sample = m_phase[23] ? -(m_amp * 128) : m_amp * 128;
    if (v && (m_state == S_IDLE || m_state == S_SUS)) begin
      if (m_state == S_IDLE && is_note) begin
        m_state = S_ATT; m_cur = k; m_phase = 0;
      end else if (m_state == S_SUS && !is_note) begin
        m_state = S_REL; m_pend = 0;
      end else if (m_state == S_SUS && k != m_cur) begin
        m_state = S_REL; m_pend = 1; m_pend_note = k;
      end
    end
    if (tk) begin
      case (m_state)
        S_ATT: begin
          m_amp = (m_amp + 8 > 255) ? 255 : m_amp + 8;
          m_phase = (m_phase + inc_tab[m_cur]) % (1 << 24);
          if (m_amp == 255) m_state = S_SUS;
        end
        S_SUS: m_phase = (m_phase + inc_tab[m_cur]) % (1 << 24);
        S_REL: begin
          m_amp = (m_amp < 8) ? 0 : m_amp - 8;
          m_phase = (m_phase + inc_tab[m_cur]) % (1 << 24);
          if (m_amp == 0) begin
            m_phase = 0;
            if (m_pend) begin
              m_state = S_ATT; m_cur = m_pend_note; m_pend = 0;
            end else begin
              m_state = S_IDLE; m_cur = 0;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive on the falling edge, update the model at the rising edge, compare just after it
  task automatic step(input bit r, input bit v, input logic [5:0] idx, input bit tk);
    @(negedge clk);
    rst = r;
    bus.note_valid_in  = v;
    bus.note_index_in  = idx;
    bus.sample_tick_in = tk;
    @(posedge clk);
    model_step(r, v, idx, tk);
    #1;
    check("state", bus.state_out, m_state);
    check("ready", bus.note_ready_out, (m_state == S_IDLE || m_state == S_SUS) ? 1 : 0);
    check("phase", bus.phase_out, m_phase);
    check("sample_valid", bus.sample_valid_out, m_svalid);
    check("sample", bus.sample_out, m_sample);
  endtask

  task automatic tick_until(input int target, output int n);
    n = 0;
    while (int'(bus.state_out) != target && n < 200) begin
      step(0, 0, 6'h00, 1);
      n++;
    end
  endtask

  initial begin
    int n;
    int mode;
    bit r, v, tk;
    logic [5:0] idx;
    real f;

    for (int k = 0; k < 22; k++) inc_tab[k] = 0;
    for (int k = 1; k < 22; k++) begin
      f = (real'(NOTE_BIN_FLOOR[k-1]) + real'(NOTE_BIN_FLOOR[k])) / 2.0 * real'(FS_HZ) / real'(FFT_N);
      inc_tab[k] = $rtoi(f * 16777216.0 / real'(FS_HZ) + 0.5);
    end

    rst = 1'b1;
    bus.note_valid_in = 1'b0;
    bus.note_index_in = '0;
    bus.sample_tick_in = 1'b0;

    step(1, 0, 6'h00, 0);
    step(1, 0, 6'h00, 1);
    check("rst_state", bus.state_out, S_IDLE);
    check("rst_ready", bus.note_ready_out, 1);
    check("rst_sample", bus.sample_out, 0);
    repeat (5) step(0, 0, 6'h00, 1);
    check("idle_phase", bus.phase_out, 0);
    check("idle_sample", bus.sample_out, 0);

    // Note 1 attack; a note offered mid-attack must be dropped
    step(0, 1, 6'h21, 0);
    check("accept_att", bus.state_out, S_ATT);
    n = 0;
    while (int'(bus.state_out) != S_SUS && n < 200) begin
      step(0, (n == 5), 6'h25, 1);
      n++;
      if (n == 1) check("first_inc", bus.phase_out, inc_tab[1]);
    end
    check("attack_ticks", n, 32);

    repeat (3) step(0, 0, 6'h00, 1);
    step(0, 1, 6'h21, 1);
    check("same_note", bus.state_out, S_SUS);
    step(0, 1, 6'h25, 0);
    check("new_note_rel", bus.state_out, S_REL);
    tick_until(S_ATT, n);
    check("release_ticks", n, 32);
    check("restart_phase", bus.phase_out, 0);
    step(0, 0, 6'h00, 1);
    check("note5_inc", bus.phase_out, inc_tab[5]);

    // Silence from sustain drains to idle
    tick_until(S_SUS, n);
    step(0, 1, 6'h3F, 0);
    check("silence_rel", bus.state_out, S_REL);
    tick_until(S_IDLE, n);
    check("silence_ticks", n, 32);
    step(0, 0, 6'h00, 1);
    check("idle_after_rel", bus.sample_out, 0);

    // Acceptance coincident with a tick already steps the envelope
    step(0, 1, 6'h2A, 1);
    check("coinc_state", bus.state_out, S_ATT);
    step(0, 0, 6'h00, 1);
    check("coinc_amp8", bus.sample_out, 1024);

    // Reset in the middle of a release with a pending note
    tick_until(S_SUS, n);
    step(0, 1, 6'h33, 0);
    repeat (4) step(0, 0, 6'h00, 1);
    step(1, 0, 6'h00, 1);
    check("rst_mid_rel", bus.state_out, S_IDLE);
    repeat (50) step(0, 0, 6'h00, 1);
    check("no_late_attack", bus.state_out, S_IDLE);
    check("no_late_phase", bus.phase_out, 0);

    mode = 0;
    for (int i = 0; i < 16000; i++) begin
      if (i % 500 == 0) mode = $urandom_range(0, 2);
      r  = ($urandom_range(0, 2999) == 0);
      v  = ($urandom_range(0, 24) == 0);
      tk = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idx = {1'b1, 5'($urandom_range(1, 21))};
      else idx = 6'($urandom);
      step(r, v, idx, tk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
